sp_link_ctrl: RTL
=================

Name: sp_link_ctrl

Overview:
Link-synchronisation controller that sequences the serial-to-parallel receive path. It observes the 8-bit parallel words produced each clk_f cycle and hunts for the 0xBC comma idle pattern. If no comma appears, it requests bit-slips from the deserialiser. It declares the link active after a run of consecutive commas, then forwards payload with a valid flag and drops back to search on loss of sync.

Parameters:
COMMA, 8'hBC, idle/comma symbol
LOCK_CNT, 4, consecutive commas required to declare the link active (range 1..15)
SLIP_WINDOW, 16, cycles without a comma in SEARCH before a bit_slip pulse (range 2..255)
MAX_GAP, 64, consecutive non-comma words in ACTIVE that declare loss of sync (range 2..255)

Ports:
clk_f  input  1  word clock, all logic on the rising edge
reset  input  1  synchronous, active-high reset
link_en  input  1  1 = controller runs; 0 = forced to SEARCH, no slips
data_in  input  8  parallel word from the deserialiser, new word each clk_f
data_out  output  8  registered copy of data_in
valid_out  output  1  data_out holds payload (link active and word != COMMA)
active  output  1  link is in the ACTIVE state
bit_slip  output  1  one-cycle request to the deserialiser to shift alignment by 1 bit
sync_lost  output  1  one-cycle pulse on the ACTIVE -> SEARCH transition caused by gap overflow

Behaviour:
- Reset (reset=1 at the clock edge):
  - state=SEARCH; all outputs 0.
  - Internal counters: bc_cnt=0, win_cnt=0, gap_cnt=0.
- Reset has priority over every other condition, including mid-lock and mid-slip.
- data_out <= data_in every non-reset cycle, in all states. Latency is 1 clk_f.
- link_en=0 (non-reset):
  - state <= SEARCH; all counters cleared.
  - valid_out, active, bit_slip, sync_lost <= 0; data_out still updates.
- SEARCH:
  - data_in==COMMA: go to CHECK, bc_cnt<=1, win_cnt<=0.
  - Otherwise win_cnt increments. When win_cnt==SLIP_WINDOW-1: bit_slip<=1 for exactly one cycle and win_cnt<=0.
  - Pulses are therefore spaced exactly SLIP_WINDOW cycles apart. The window restart is the settling holdoff after a slip.
- CHECK:
  - data_in==COMMA and bc_cnt+1==LOCK_CNT: go to ACTIVE, active<=1, gap_cnt<=0.
  - data_in==COMMA otherwise: bc_cnt increments.
  - data_in!=COMMA: go to SEARCH; bc_cnt and win_cnt <= 0; no slip in that cycle.
  - LOCK_CNT=1: a single comma in SEARCH goes directly to ACTIVE.
- ACTIVE:
  - valid_out <= (data_in != COMMA).
  - Comma: gap_cnt<=0.
  - Non-comma: gap_cnt increments.
  - If gap_cnt==MAX_GAP-1 and data_in!=COMMA (the MAX_GAP-th consecutive non-comma): go to SEARCH; active<=0, valid_out<=0, sync_lost<=1 for one cycle; all counters cleared. The word that triggers loss is not flagged valid.
- active stays high on the same cycle valid_out is updated. Outputs are registered, so active rises on the same edge that captures the locking comma (valid_out=0 there).
- bit_slip is asserted only in SEARCH; sync_lost only on gap overflow. They are never high together.
- Counter widths hold their parameter ranges without wrap. Comparisons use equality, so counters never exceed their terminal value.

Optional Feature:
SP_LINK_STATS_EN
- Defined: adds outputs slip_count[7:0] and loss_count[7:0]. They count bit_slip and sync_lost pulses, saturate at 8'hFF, and are cleared only by reset (link_en=0 does not clear them).
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, link_en=1, data_in=8'h00 for 40 cycles -> bit_slip pulses in cycles 16 and 32 after reset release; active=0, valid_out=0 throughout.
- 4 consecutive 8'hBC then 8'h55, 8'hA3 -> active=1 on the edge after the 4th BC; data_out=8'h55 with valid_out=1 the next cycle, then 8'hA3 valid; bit_slip never asserted.
- 3 BC, 8'h12, 4 BC -> returns to SEARCH after 8'h12 (active stays 0); locks after the 4 following BC; no slip if the total idle stays under 16.
- Locked link, then 64 consecutive 8'h77 -> valid_out=1 for the first 63 words; on the 64th, sync_lost pulses for 1 cycle and active=0, valid_out=0; an interleaved BC at word 50 prevents the loss.
- Locked link, reset=1 for 1 cycle mid-stream -> next cycle all outputs 0, state SEARCH; drop link_en mid-lock (2 BC seen) -> bc_cnt cleared, 4 fresh BC needed after re-enable.
- With SP_LINK_STATS_EN: 300 cycles of 8'h00 -> slip_count=18; force 2 losses -> loss_count=2; link_en toggle leaves counts unchanged.

Source files
------------

// File: rtl/sp_link_ctrl_if.sv
// Word-side bus of the link-synchronisation controller: deserialiser word in, payload/status out.
// With SP_LINK_STATS_EN defined it also carries the slip/loss statistics counters.
interface sp_link_ctrl_if;
  logic       link_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       bit_slip;
  logic       sync_lost;
`ifdef SP_LINK_STATS_EN
  logic [7:0] slip_count;
  logic [7:0] loss_count;

  modport master (output link_en, data_in,
                  input  data_out, valid_out, active, bit_slip, sync_lost, slip_count, loss_count);
  modport slave  (input  link_en, data_in,
                  output data_out, valid_out, active, bit_slip, sync_lost, slip_count, loss_count);
`else
  modport master (output link_en, data_in,
                  input  data_out, valid_out, active, bit_slip, sync_lost);
  modport slave  (input  link_en, data_in,
                  output data_out, valid_out, active, bit_slip, sync_lost);
`endif
endinterface

// File: rtl/sp_link_ctrl.sv
// Comma-hunting link controller: requests bit slips until commas align, locks after LOCK_CNT
// commas in a row, forwards payload while active. SP_LINK_STATS_EN adds slip/loss counters.
module sp_link_ctrl #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         LOCK_CNT    = 4,
  parameter int         SLIP_WINDOW = 16,
  parameter int         MAX_GAP     = 64
) (
  input logic           clk_f,
  input logic           reset,
  sp_link_ctrl_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, CHECK, ACTIVE} state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [7:0] WIN_LAST  = 8'(SLIP_WINDOW - 1);
  localparam logic [7:0] GAP_LAST  = 8'(MAX_GAP - 1);

  state_t     state, state_next;
  logic [3:0] bc_cnt, bc_next;
  logic [7:0] win_cnt, win_next;
  logic [7:0] gap_cnt, gap_next;
  logic [7:0] data_reg;
  logic       valid_reg, valid_next;
  logic       slip_reg, slip_next;
  logic       lost_reg, lost_next;
  logic       is_comma;

  assign is_comma = (bus.data_in == COMMA);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    bc_next    = bc_cnt;
    win_next   = win_cnt;
    gap_next   = gap_cnt;
    valid_next = 1'b0;
    slip_next  = 1'b0;
    lost_next  = 1'b0;

    if (!bus.link_en) begin
      state_next = SEARCH;
      bc_next    = '0;
      win_next   = '0;
      gap_next   = '0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (is_comma) begin
            win_next = '0;
            if (LOCK_CNT == 1) begin
              state_next = ACTIVE;
              gap_next   = '0;
            end else begin
              state_next = CHECK;
              bc_next    = 4'd1;
            end
          end else if (win_cnt == WIN_LAST) begin
            // The window restart doubles as settling time after the slip.
            slip_next = 1'b1;
            win_next  = '0;
          end else begin
            win_next = win_cnt + 8'd1;
          end
        end

        CHECK: begin
          if (is_comma) begin
            if (bc_cnt == LOCK_LAST) begin
              state_next = ACTIVE;
              bc_next    = '0;
              gap_next   = '0;
            end else begin
              bc_next = bc_cnt + 4'd1;
            end
          end else begin
            state_next = SEARCH;
            bc_next    = '0;
            win_next   = '0;
          end
        end

        ACTIVE: begin
          if (is_comma) begin
            gap_next = '0;
          end else if (gap_cnt == GAP_LAST) begin
            // The word that overflows the gap is not forwarded as payload.
            state_next = SEARCH;
            lost_next  = 1'b1;
            bc_next    = '0;
            win_next   = '0;
            gap_next   = '0;
          end else begin
            gap_next   = gap_cnt + 8'd1;
            valid_next = 1'b1;
          end
        end

        default: state_next = SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the reset is synchronous to clk_f.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      state     <= SEARCH;
      bc_cnt    <= '0;
      win_cnt   <= '0;
      gap_cnt   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      slip_reg  <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      state     <= state_next;
      bc_cnt    <= bc_next;
      win_cnt   <= win_next;
      gap_cnt   <= gap_next;
      data_reg  <= bus.data_in;
      valid_reg <= valid_next;
      slip_reg  <= slip_next;
      lost_reg  <= lost_next;
    end
  end

  assign bus.data_out  = data_reg;
  assign bus.valid_out = valid_reg;
  assign bus.active    = (state == ACTIVE);
  assign bus.bit_slip  = slip_reg;
  assign bus.sync_lost = lost_reg;

`ifdef SP_LINK_STATS_EN
  logic [7:0] slip_count, loss_count;

  // Saturating counters survive link_en drops; only reset clears them.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      slip_count <= '0;
      loss_count <= '0;
    end else begin
      if (slip_next && slip_count != 8'hFF) slip_count <= slip_count + 8'd1;
      if (lost_next && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
    end
  end

  assign bus.slip_count = slip_count;
  assign bus.loss_count = loss_count;
`endif

endmodule
